// File: rtl/seq_divider_64.sv
// seq_divider_64: iterative restoring divider for RV64M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle; divide-by-zero and signed overflow take a
// one-cycle shortcut straight to the fix-up state.
module seq_divider_64 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvsr;
  logic [XLEN-1:0] r_dvnd;
  logic            r_sgn_a;
  logic            r_sgn_b;
  logic            r_zero;
  logic            r_ovf;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_r;
  logic            r_dz;
  logic            r_done;

  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_is_zero;
  logic            w_is_ovf;
  logic [XLEN-1:0] w_shift_lo;
  logic            w_borrow;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_neg_a   = is_signed & dividend[XLEN-1];
  assign w_neg_b   = is_signed & divisor[XLEN-1];
  assign w_abs_a   = w_neg_a ? (~dividend + 1'b1) : dividend;
  assign w_abs_b   = w_neg_b ? (~divisor + 1'b1) : divisor;
  assign w_is_zero = (divisor == '0);
  assign w_is_ovf  = is_signed & (dividend == MIN_VAL) & (divisor == '1);

  // The XLEN+1-bit trial is split: if the bit shifted out of r_rem is set the
  // shifted value is already >= 2^XLEN > divisor, so the trial succeeds and the
  // low XLEN bits of the modular difference are the exact new remainder.
  assign w_shift_lo           = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign {w_borrow, w_diff}   = {1'b0, w_shift_lo} - {1'b0, r_dvsr};
  assign w_ge                 = r_rem[XLEN-1] | ~w_borrow;
  assign w_rem_next           = w_ge ? w_diff : w_shift_lo;
  assign w_quo_next           = {r_quo[XLEN-2:0], w_ge};

  // Final result selection, including sign correction and the special cases
  always_comb begin
    w_q_fix = r_quo;
    w_r_fix = r_rem;
    if (r_zero) begin
      w_q_fix = '1;
      w_r_fix = r_dvnd;
    end else if (r_ovf) begin
      w_q_fix = MIN_VAL;
      w_r_fix = '0;
    end else begin
      if (r_sgn_a ^ r_sgn_b) w_q_fix = ~r_quo + 1'b1;
      if (r_sgn_a)           w_r_fix = ~r_rem + 1'b1;
    end
  end

  // Control FSM and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_dvnd  <= '0;
      r_sgn_a <= 1'b0;
      r_sgn_b <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvnd  <= dividend;
            r_sgn_a <= w_neg_a;
            r_sgn_b <= w_neg_b;
            r_zero  <= w_is_zero;
            r_ovf   <= w_is_ovf & ~w_is_zero;
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dvsr  <= w_abs_b;
            if (w_is_zero || w_is_ovf) begin
              r_state <= S_FIX;
            end else begin
              r_cnt   <= CW'(XLEN);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers and the single-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        r_q  <= w_q_fix;
        r_r  <= w_r_fix;
        r_dz <= r_zero;
      end
    end
  end

  assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dz;

endmodule
